multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the RV32I core variant with a single shared instruction/data memory. It sequences fetch, decode, execute, memory and writeback over several clocks and drives every datapath enable and mux select, including the memory request handshake. It reuses the core's ALU-control and immediate encodings, so it replaces the single-cycle combinational decoder without changing the ALU or the immediate generator.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode from the registered instruction register (IR)
- funct3  in  3  IR[14:12]
- funct75  in  1  IR[30]
- ZF  in  1  ALU zero flag, same cycle
- SF  in  1  ALU sign flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a write; valid only while mem_req=1
- adr_src  out  1  memory address: 0=PC, 1=ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from the result mux
- reg_write  out  1  register-file write
- result_src  out  2  00=ALUOut, 01=memory data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B
- alu_ctrl  out  3  000 add, 001 sll, 010 sub, 100 xor, 101 srl, 110 or, 111 and
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky trap indicator
- state  out  4  current state code, for debug

## Operation
- Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-type, 1100011 branch.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, TRAP=15.
- Any output not listed for a state is 0.
- FETCH
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=add, result_src=10.
  - ir_write and pc_write both equal mem_ready.
  - Moves to DECODE on mem_ready; otherwise stays in FETCH.
- DECODE
  - Outputs: alu_src_a=01, alu_src_b=01, imm_src=10, add, which computes the branch target into ALUOut.
  - Next state: lw or sw → MEMADR; R-type → EXECR; I-type → EXECI; branch → BRANCH; any other op → TRAP.
  - R-type or I-type with funct3 ∈ {010, 011} → TRAP.
- MEMADR
  - Outputs: alu_src_a=10, alu_src_b=01, add; imm_src=00 for lw, 01 for sw.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD
  - Outputs: mem_req=1, adr_src=1.
  - Stays until mem_ready, then moves to MEMWB.
- MEMWB
  - Outputs: result_src=01, reg_write=1, instr_done=1.
  - Next state: FETCH.
- MEMWRITE
  - Outputs: mem_req=1, mem_write=1, adr_src=1.
  - instr_done equals mem_ready; on mem_ready → FETCH.
- EXECR
  - Outputs: alu_src_a=10, alu_src_b=00.
  - Next state: ALUWB.
- EXECI
  - Outputs: alu_src_a=10, alu_src_b=01, imm_src=00.
  - Next state: ALUWB.
- ALU decode in EXECR and EXECI
  - funct3=000: sub only when op[5]=1 and funct75=1, otherwise add.
  - Other funct3 values: 001 sll, 100 xor, 101 srl, 110 or, 111 and.
- ALUWB
  - Outputs: result_src=00, reg_write=1, instr_done=1.
  - Next state: FETCH.
- BRANCH
  - Outputs: alu_src_a=10, alu_src_b=00, sub, result_src=00, instr_done=1.
  - pc_write: funct3 000 → ZF; 001 → ~ZF; 100 → SF; any other funct3 → 0 (not taken, no trap).
  - Next state: FETCH.
- TRAP
  - Outputs: illegal=1; all enables are 0.
  - Exits only on reset.

## Timing
- Reset
  - rst_n low forces state=FETCH immediately (asynchronous).
  - While rst_n is low, mem_req, ir_write, pc_write, reg_write, mem_write, instr_done and illegal are all 0.
  - The first request is issued in the first cycle after rst_n deasserts.
- Output timing
  - State-only outputs are Moore.
  - ir_write, pc_write, instr_done and alu_ctrl are combinational from state plus inputs within the same cycle.
- Latency with zero-wait memory (mem_ready high in the first request cycle)
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch: 3 cycles.
  - Each cycle with mem_ready=0 during a request adds one cycle.
- Request handshake
  - mem_req, adr_src and mem_write stay stable while waiting for mem_ready.
  - A mem_ready seen outside FETCH, MEMREAD or MEMWRITE is ignored.
- op, funct3 and funct75 are sampled only in DECODE and later states; their values during FETCH are don't-care.
- Reset mid-instruction aborts the instruction; no register or memory write occurs after rst_n falls.

## Test plan
- Reset and add
  - Stimulus: reset, then op=0110011, funct3=000, funct75=0, mem_ready always 1.
  - Required: states 0→1→6→8→0; alu_ctrl=000 in EXECR; reg_write=1 only in ALUWB; instr_done on cycle 4.
- Load with wait states
  - Stimulus: lw with mem_ready=0 for 2 cycles in MEMREAD.
  - Required: MEMREAD lasts 3 cycles with mem_req=1 and adr_src=1 held; result_src=01 and reg_write=1 in MEMWB; 7 cycles total.
- Store
  - Stimulus: sw.
  - Required: imm_src=01 in MEMADR; mem_write=1 only in MEMWRITE; reg_write never asserted.
- Branches
  - Stimulus: beq with ZF=1.
  - Required: pc_write=1 in BRANCH.
  - Stimulus: bne with ZF=1.
  - Required: pc_write=0.
  - Stimulus: blt with SF=1.
  - Required: pc_write=1.
  - Stimulus: funct3=101.
  - Required: pc_write=0.
  - Every branch returns to FETCH after 3 cycles.
- Illegal instructions
  - Stimulus: op=1101111, or R-type with funct3=010.
  - Required: TRAP (state=15) with illegal=1 held indefinitely; no enables asserted; reset clears it.
- Reset mid-instruction
  - Stimulus: pull rst_n low during MEMWRITE.
  - Required: mem_write drops immediately; state=0 afterwards.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM for a shared instruction/data memory core.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath controls.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic       ZF,
  input  logic       SF,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  state_e     state_q, state_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_write_q, mem_write_d;
  logic       adr_src_q, adr_src_d;
  logic       reg_write_q, reg_write_d;
  logic       illegal_q, illegal_d;
  logic [1:0] result_src_q, result_src_d;
  logic [1:0] alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [1:0] imm_src_q, imm_src_d;

  logic       f3_bad;
  logic       branch_taken;
  logic [2:0] exec_alu;

  always_comb begin
    f3_bad  = (funct3[2:1] == 2'b01);
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = f3_bad ? S_TRAP : S_EXECR;
          OP_I:         state_d = f3_bad ? S_TRAP : S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      // op[5] separates sw (0100011) from lw (0000011)
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // Moore outputs are decoded from the next state and registered with it
  always_comb begin
    mem_req_d    = 1'b0;
    mem_write_d  = 1'b0;
    adr_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    illegal_d    = 1'b0;
    result_src_d = 2'b00;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    imm_src_d    = 2'b00;
    case (state_d)
      S_FETCH: begin
        mem_req_d    = 1'b1;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
        imm_src_d   = 2'b10;
      end
      S_MEMADR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
        imm_src_d   = op[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req_d = 1'b1;
        adr_src_d = 1'b1;
      end
      S_MEMWB: begin
        result_src_d = 2'b01;
        reg_write_d  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        adr_src_d   = 1'b1;
      end
      S_EXECR: alu_src_a_d = 2'b10;
      S_EXECI: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
      end
      S_ALUWB:  reg_write_d = 1'b1;
      S_BRANCH: alu_src_a_d = 2'b10;
      S_TRAP:   illegal_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      mem_req_q    <= 1'b1;
      mem_write_q  <= 1'b0;
      adr_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
      result_src_q <= 2'b10;
      alu_src_a_q  <= 2'b00;
      alu_src_b_q  <= 2'b10;
      imm_src_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_write_q  <= mem_write_d;
      adr_src_q    <= adr_src_d;
      reg_write_q  <= reg_write_d;
      illegal_q    <= illegal_d;
      result_src_q <= result_src_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      imm_src_q    <= imm_src_d;
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  exec_alu = (op[5] & funct75) ? ALU_SUB : ALU_ADD;
      3'b001:  exec_alu = ALU_SLL;
      3'b100:  exec_alu = ALU_XOR;
      3'b101:  exec_alu = ALU_SRL;
      3'b110:  exec_alu = ALU_OR;
      3'b111:  exec_alu = ALU_AND;
      default: exec_alu = ALU_ADD;
    endcase
    case (funct3)
      3'b000:  branch_taken = ZF;
      3'b001:  branch_taken = ~ZF;
      3'b100:  branch_taken = SF;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    instr_done = 1'b0;
    alu_ctrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_MEMWB,
      S_ALUWB:    instr_done = 1'b1;
      S_MEMWRITE: instr_done = mem_ready;
      S_EXECR,
      S_EXECI:    alu_ctrl = exec_alu;
      S_BRANCH: begin
        alu_ctrl   = ALU_SUB;
        instr_done = 1'b1;
        pc_write   = branch_taken;
      end
      default: ;
    endcase
    // FETCH is the reset state, so its ready-driven enables must be masked by reset
    if (!rst_n) begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign mem_req    = mem_req_q & rst_n;
  assign mem_write  = mem_write_q;
  assign adr_src    = adr_src_q;
  assign reg_write  = reg_write_q;
  assign illegal    = illegal_q;
  assign result_src = result_src_q;
  assign alu_src_a  = alu_src_a_q;
  assign alu_src_b  = alu_src_b_q;
  assign imm_src    = imm_src_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: per-cycle state and control checks.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct75;
  logic       ZF, SF;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_ctrl;
  logic       instr_done, illegal;
  logic [3:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct75(funct75),
    .ZF(ZF), .SF(SF), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = OP_R; funct3 = 3'b000; funct75 = 1'b0;
    ZF = 1'b0; SF = 1'b0;
    #3;
    n_chk++;
    if (state !== 4'd0) $display("FAIL reset_state: got %0d want 0", state);
    else n_pass++;
    n_chk++;
    if ({mem_req, ir_write, pc_write, reg_write, mem_write, instr_done, illegal} !== 7'b0)
      $display("FAIL reset_enables: got %b want 0000000",
               {mem_req, ir_write, pc_write, reg_write, mem_write, instr_done, illegal});
    else n_pass++;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (mem_req !== 1'b1) $display("FAIL reset_first_req: got %b want 1", mem_req);
    else n_pass++;
  endtask

  task automatic test_r_add();
    logic [3:0] st_exp [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
    op = OP_R; funct3 = 3'b000; funct75 = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if (state !== st_exp[i]) $display("FAIL radd_state c%0d: got %0d want %0d", i, state, st_exp[i]);
      else n_pass++;
      n_chk++;
      if (reg_write !== (i == 3)) $display("FAIL radd_reg_write c%0d: got %b want %b", i, reg_write, i == 3);
      else n_pass++;
      n_chk++;
      if (instr_done !== (i == 3)) $display("FAIL radd_done c%0d: got %b want %b", i, instr_done, i == 3);
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if (alu_ctrl !== 3'b000) $display("FAIL radd_alu: got %b want 000", alu_ctrl);
        else n_pass++;
      end
      tick();
    end
    #1;
    n_chk++;
    if (state !== 4'd0) $display("FAIL radd_return: got %0d want 0", state);
    else n_pass++;
  endtask

  task automatic test_load_wait();
    logic [3:0] st_exp [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       rdy    [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    op = OP_LW; funct3 = 3'b010; funct75 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      n_chk++;
      if (state !== st_exp[i]) $display("FAIL lw_state c%0d: got %0d want %0d", i, state, st_exp[i]);
      else n_pass++;
      if (i >= 3 && i <= 5) begin
        n_chk++;
        if ({mem_req, adr_src, mem_write} !== 3'b110)
          $display("FAIL lw_memread_req c%0d: got %b want 110", i, {mem_req, adr_src, mem_write});
        else n_pass++;
      end
      if (i == 6) begin
        n_chk++;
        if ({result_src, reg_write, instr_done} !== 4'b0111)
          $display("FAIL lw_memwb: got %b want 0111", {result_src, reg_write, instr_done});
        else n_pass++;
      end else begin
        n_chk++;
        if (reg_write !== 1'b0) $display("FAIL lw_reg_write c%0d: got %b want 0", i, reg_write);
        else n_pass++;
      end
      tick();
    end
    #1;
    n_chk++;
    if (state !== 4'd0) $display("FAIL lw_return: got %0d want 0", state);
    else n_pass++;
  endtask

  task automatic test_store();
    logic [3:0] st_exp [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    op = OP_SW; funct3 = 3'b010; funct75 = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++;
      if (state !== st_exp[i]) $display("FAIL sw_state c%0d: got %0d want %0d", i, state, st_exp[i]);
      else n_pass++;
      n_chk++;
      if (mem_write !== (i == 3)) $display("FAIL sw_mem_write c%0d: got %b want %b", i, mem_write, i == 3);
      else n_pass++;
      n_chk++;
      if (reg_write !== 1'b0) $display("FAIL sw_reg_write c%0d: got %b want 0", i, reg_write);
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if (imm_src !== 2'b01) $display("FAIL sw_imm_src: got %b want 01", imm_src);
        else n_pass++;
      end
      if (i == 3) begin
        n_chk++;
        if ({mem_req, adr_src, instr_done} !== 3'b111)
          $display("FAIL sw_memwrite: got %b want 111", {mem_req, adr_src, instr_done});
        else n_pass++;
      end
      tick();
    end
    #1;
    n_chk++;
    if (state !== 4'd0) $display("FAIL sw_return: got %0d want 0", state);
    else n_pass++;
  endtask

  task automatic test_branches();
    logic [2:0] f3  [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    logic       zf  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       sf  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       tkn [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] st_exp [3] = '{4'd0, 4'd1, 4'd9};
    op = OP_BR; funct75 = 1'b0; mem_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      funct3 = f3[v]; ZF = zf[v]; SF = sf[v];
      for (int i = 0; i < 3; i++) begin
        #1;
        n_chk++;
        if (state !== st_exp[i]) $display("FAIL br%0d_state c%0d: got %0d want %0d", v, i, state, st_exp[i]);
        else n_pass++;
        if (i == 2) begin
          n_chk++;
          if (pc_write !== tkn[v]) $display("FAIL br%0d_pc_write: got %b want %b", v, pc_write, tkn[v]);
          else n_pass++;
          n_chk++;
          if ({alu_ctrl, instr_done, reg_write} !== 5'b01010)
            $display("FAIL br%0d_ctrl: got %b want 01010", v, {alu_ctrl, instr_done, reg_write});
          else n_pass++;
        end
        tick();
      end
      #1;
      n_chk++;
      if (state !== 4'd0) $display("FAIL br%0d_return: got %0d want 0", v, state);
      else n_pass++;
      #(-1 + 1);
    end
    ZF = 1'b0; SF = 1'b0;
  endtask

  task automatic test_alu_decode();
    logic [6:0] ops [5] = '{OP_R, OP_I, OP_I, OP_R, OP_R};
    logic [2:0] f3  [5] = '{3'b000, 3'b000, 3'b101, 3'b111, 3'b001};
    logic       f75 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] alu [5] = '{3'b010, 3'b000, 3'b101, 3'b111, 3'b001};
    logic [3:0] ex  [5] = '{4'd6, 4'd7, 4'd7, 4'd6, 4'd6};
    mem_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      op = ops[v]; funct3 = f3[v]; funct75 = f75[v];
      tick(); tick();
      #1;
      n_chk++;
      if (state !== ex[v]) $display("FAIL alu%0d_state: got %0d want %0d", v, state, ex[v]);
      else n_pass++;
      n_chk++;
      if (alu_ctrl !== alu[v]) $display("FAIL alu%0d_ctrl: got %b want %b", v, alu_ctrl, alu[v]);
      else n_pass++;
      tick(); tick();
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [2] = '{7'b1101111, OP_R};
    logic [2:0] f3  [2] = '{3'b000, 3'b010};
    mem_ready = 1'b1; funct75 = 1'b0;
    for (int v = 0; v < 2; v++) begin
      op = ops[v]; funct3 = f3[v];
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
        #1;
        n_chk++;
        if ({state, illegal} !== 5'b11111) $display("FAIL ill%0d_trap c%0d: got %b want 11111", v, i, {state, illegal});
        else n_pass++;
        n_chk++;
        if ({mem_req, ir_write, pc_write, reg_write, mem_write, instr_done} !== 6'b0)
          $display("FAIL ill%0d_enables c%0d: got %b want 000000", v, i,
                   {mem_req, ir_write, pc_write, reg_write, mem_write, instr_done});
        else n_pass++;
        tick();
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({state, illegal} !== 5'b00000) $display("FAIL ill%0d_reset: got %b want 00000", v, {state, illegal});
      else n_pass++;
      tick();
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    op = OP_SW; funct3 = 3'b010; funct75 = 1'b0; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    n_chk++;
    if ({state, mem_write} !== 5'b01011) $display("FAIL mid_memwrite: got %b want 01011", {state, mem_write});
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({state, mem_write, mem_req, reg_write, instr_done} !== 8'b0)
      $display("FAIL mid_abort: got %b want 00000000", {state, mem_write, mem_req, reg_write, instr_done});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({state, mem_req, mem_write} !== 6'b000010)
      $display("FAIL mid_restart: got %b want 000010", {state, mem_req, mem_write});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_load_wait();
    test_store();
    test_branches();
    test_alu_decode();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
